// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small first-word-fall-through FIFO.
// Flags bad stop bits and bytes dropped on a full FIFO.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 4167,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic                          rx_i,
   output logic [7:0]                    rx_data_o,
   output logic                          rx_valid_o,
   input  logic                          rx_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          busy_o,
   output logic                          frame_err_o,
   output logic                          overrun_o,
   input  logic                          clr_err_i
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    sh;

   logic rx_m;
   logic rx_s;
   logic rx_s_d;
   logic start_edge;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic          full;
   logic          wr_en;

   // Idle-high reset values keep a reset from looking like a start edge.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rx_m   <= 1'b1;
         rx_s   <= 1'b1;
         rx_s_d <= 1'b1;
      end else begin
         rx_m   <= rx_i;
         rx_s   <= rx_m;
         rx_s_d <= rx_s;
      end
   end

   assign start_edge = rx_s_d & ~rx_s;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         sh          <= '0;
         frame_err_o <= 1'b0;
      end else begin
         frame_err_o <= 1'b0;
         cnt         <= cnt + 1'b1;
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (start_edge) begin
                  state <= START;
               end
            end
            START: begin
               if (cnt == HALF_BIT) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DATA: begin
               if (cnt == FULL_BIT) begin
                  cnt         <= '0;
                  sh[bit_idx] <= rx_s;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            STOP: begin
               if (cnt == FULL_BIT) begin
                  cnt         <= '0;
                  frame_err_o <= ~rx_s;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy_o = (state != IDLE);

   // A good stop bit hands the assembled byte straight to the FIFO.
   assign push  = (state == STOP) && (cnt == FULL_BIT) && rx_s;
   assign pop   = rx_valid_o & rx_ready_i;
   assign full  = (fifo_level_o == DEPTH);
   assign wr_en = push & (~full | pop);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level_o <= '0;
         overrun_o    <= 1'b0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= sh;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({wr_en, pop})
            2'b10:   fifo_level_o <= fifo_level_o + 1'b1;
            2'b01:   fifo_level_o <= fifo_level_o - 1'b1;
            default: fifo_level_o <= fifo_level_o;
         endcase
         if (push && !wr_en) begin
            overrun_o <= 1'b1;
         end else if (clr_err_i) begin
            overrun_o <= 1'b0;
         end
      end
   end

   assign rx_valid_o = (fifo_level_o != '0);
   assign rx_data_o  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo with 16-cycle bits and a 4-entry FIFO.
// Directed serial frames; a monitor checks every popped byte in order.
module tb_uart_rx_fifo;

   localparam int BIT = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic [2:0] level;
   logic       busy;
   logic       fe;
   logic       ovr;
   logic       clr;

   int n_cmp = 0;
   int n_err = 0;
   int fe_cycles = 0;
   int fe0;
   bit busy_seen = 0;

   logic [7:0] exp_q[$];
   logic [7:0] b;

   uart_rx_fifo #(
      .CLKS_PER_BIT(BIT),
      .FIFO_DEPTH(4)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .rx_i(rx),
      .rx_data_o(data),
      .rx_valid_o(valid),
      .rx_ready_i(ready),
      .fifo_level_o(level),
      .busy_o(busy),
      .frame_err_o(fe),
      .overrun_o(ovr),
      .clr_err_i(clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] v, input logic stop);
      rx = 1'b0;
      tick(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = v[i];
         tick(BIT);
      end
      rx = stop;
      tick(BIT);
   endtask

   task automatic pop_n(input int n);
      ready = 1'b1;
      tick(n);
      ready = 1'b0;
      tick(1);
   endtask

   // Monitor: a pop happens on the next rising edge when valid && ready.
   always @(negedge clk) begin
      if (fe) fe_cycles++;
      if (busy) busy_seen = 1'b1;
      if (!rst && valid && ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected: got %0h expected none", data);
         end else begin
            b = exp_q.pop_front();
            if (data !== b) begin
               n_err++;
               $display("FAIL pop_data: got %0h expected %0h", data, b);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      rx = 1'b1;
      ready = 1'b0;
      clr = 1'b0;
      tick(3);
      check("rst_valid", 32'(valid), 0);
      check("rst_level", 32'(level), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_fe", 32'(fe), 0);
      check("rst_ovr", 32'(ovr), 0);
      check("rst_data", 32'(data), 0);
      rst = 1'b0;
      tick(4);

      // Single byte held in the FIFO, then popped.
      exp_q.push_back(8'h0F);
      send(8'h0F, 1'b1);
      tick(2);
      check("t1_valid", 32'(valid), 1);
      check("t1_data", 32'(data), 32'h0F);
      check("t1_level", 32'(level), 1);
      pop_n(1);
      check("t1_level_after", 32'(level), 0);

      // Fill the FIFO back to back.
      fe0 = fe_cycles;
      exp_q.push_back(8'hA5);
      send(8'hA5, 1'b1);
      exp_q.push_back(8'h3C);
      send(8'h3C, 1'b1);
      exp_q.push_back(8'hFF);
      send(8'hFF, 1'b1);
      exp_q.push_back(8'h00);
      send(8'h00, 1'b1);
      tick(2);
      check("t2_level", 32'(level), 4);
      check("t2_ovr", 32'(ovr), 0);

      // Overrun on a full FIFO; dropped byte never reaches the queue.
      send(8'h61, 1'b1);
      tick(2);
      check("t3_ovr", 32'(ovr), 1);
      check("t3_level", 32'(level), 4);
      check("t3_head", 32'(data), 32'hA5);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("t3_ovr_clr", 32'(ovr), 0);
      pop_n(6);
      check("t2_drain_level", 32'(level), 0);
      check("t2_no_fe", 32'(fe_cycles - fe0), 0);

      // Bad stop bit, then a clean frame.
      fe0 = fe_cycles;
      send(8'h55, 1'b0);
      rx = 1'b1;
      tick(2 * BIT);
      check("t4_fe_width", 32'(fe_cycles - fe0), 1);
      check("t4_level", 32'(level), 0);
      exp_q.push_back(8'h3D);
      send(8'h3D, 1'b1);
      tick(2);
      check("t4_level_good", 32'(level), 1);
      pop_n(1);

      // Short low glitch is rejected at mid start bit.
      fe0 = fe_cycles;
      busy_seen = 1'b0;
      rx = 1'b0;
      tick(5);
      rx = 1'b1;
      tick(40);
      check("t5_busy_seen", 32'(busy_seen), 1);
      check("t5_busy", 32'(busy), 0);
      check("t5_level", 32'(level), 0);
      check("t5_fe", 32'(fe_cycles - fe0), 0);
      check("t5_ovr", 32'(ovr), 0);

      // Reset in the middle of data bit 3 of 0x77.
      b = 8'h77;
      rx = 1'b0;
      tick(BIT);
      for (int i = 0; i < 3; i++) begin
         rx = b[i];
         tick(BIT);
      end
      rx = b[3];
      tick(BIT / 2);
      check("t6_busy_pre", 32'(busy), 1);
      rst = 1'b1;
      rx = 1'b1;
      tick(1);
      check("t6_valid", 32'(valid), 0);
      check("t6_level", 32'(level), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_fe", 32'(fe), 0);
      check("t6_ovr", 32'(ovr), 0);
      check("t6_data", 32'(data), 0);
      rst = 1'b0;
      tick(2 * BIT);
      exp_q.push_back(8'h3D);
      send(8'h3D, 1'b1);
      tick(2);
      check("t6_level_good", 32'(level), 1);
      pop_n(1);
      check("t6_level_after", 32'(level), 0);
      check("queue_empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
